dbram_be: RTL and testbench

Parametrised single-clock true-dual-port block RAM: the next generation of the team's 32-bit dual-port BRAM. It adds configurable data width, per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register, defined same-word collision arbitration and a reset-time clear engine. It sits between CPU/DMA masters and on-chip storage, port A for the CPU and port B for a peripheral or DMA engine.

---
 rtl/dbram_be.sv | 134 +++++++++++++
 tb/tb_dbram_be.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbram_be.sv
// True-dual-port block RAM with per-byte write enables and selectable read-during-write.
// It also has an optional output register and a clear engine that zeroes the array after reset.
module dbram_be #(
  parameter int    data_width     = 32,
  parameter int    adr_width      = 11,
  parameter string init_file      = "none",
  parameter int    rdw_mode       = 0,
  parameter int    out_reg        = 0,
  parameter int    clear_on_reset = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [data_width-1:0]   a_do,
  input  logic [data_width/8-1:0] a_sel,
  input  logic                    a_we,
  input  logic [15:0]             a_a,
  output logic [data_width-1:0]   a_di,
  input  logic [data_width-1:0]   b_do,
  input  logic [data_width/8-1:0] b_sel,
  input  logic                    b_we,
  input  logic [15:0]             b_a,
  output logic [data_width-1:0]   b_di,
  output logic                    busy
);
  localparam int NB    = data_width / 8;
  localparam int AB    = $clog2(NB);
  localparam int IW    = adr_width - AB;
  localparam int DEPTH = 1 << IW;

  typedef enum logic {ST_READY = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                state_q;
  logic [IW-1:0]         cnt_q;
  logic [data_width-1:0] mem_q [DEPTH];

  logic [IW-1:0]         a_idx, b_idx;
  logic [data_width-1:0] a_wmask, b_wmask;
  logic [data_width-1:0] a_rd_p1_d, a_rd_p1_q, b_rd_p1_d, b_rd_p1_q;
  logic                  unused_addr_bits;

  function automatic logic [data_width-1:0] byte_mask(input logic [NB-1:0] en);
    logic [data_width-1:0] m;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{en[i]}};
    return m;
  endfunction

  function automatic logic [data_width-1:0] rdw_word(input logic [data_width-1:0] old_w,
                                                     input logic [data_width-1:0] wdata,
                                                     input logic [data_width-1:0] mask);
    if (rdw_mode != 0) return (old_w & ~mask) | (wdata & mask);
    return old_w;
  endfunction

  assign a_idx            = a_a[adr_width-1:AB];
  assign b_idx            = b_a[adr_width-1:AB];
  assign unused_addr_bits = ^{a_a, b_a};
  assign a_wmask          = byte_mask(a_sel & {NB{a_we}});
  assign b_wmask          = byte_mask(b_sel & {NB{b_we}});
  assign busy             = (state_q == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (clear_on_reset != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == {IW{1'b1}}) state_q <= ST_READY;
    end
  end

  // B is applied first so A wins bytes both ports enable on a shared word.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_we && b_sel[i]) mem_q[b_idx][i*8 +: 8] <= b_do[i*8 +: 8];
        if (a_we && a_sel[i]) mem_q[a_idx][i*8 +: 8] <= a_do[i*8 +: 8];
      end
    end
  end

  // Stage p1: array read; each port only sees its own write, the other port sees old data.
  always_comb begin
    a_rd_p1_d = '0;
    b_rd_p1_d = '0;
    if (state_q == ST_READY) begin
      a_rd_p1_d = rdw_word(mem_q[a_idx], a_do, a_wmask);
      b_rd_p1_d = rdw_word(mem_q[b_idx], b_do, b_wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_p1_q <= '0;
      b_rd_p1_q <= '0;
    end else begin
      a_rd_p1_q <= a_rd_p1_d;
      b_rd_p1_q <= b_rd_p1_d;
    end
  end

  generate
    if (out_reg != 0) begin : g_out_reg
      logic [data_width-1:0] a_rd_p2_d, a_rd_p2_q, b_rd_p2_d, b_rd_p2_q;

      // Stage p2: optional output register, forced to zero while clearing.
      always_comb begin
        a_rd_p2_d = '0;
        b_rd_p2_d = '0;
        if (state_q == ST_READY) begin
          a_rd_p2_d = a_rd_p1_q;
          b_rd_p2_d = b_rd_p1_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rd_p2_q <= '0;
          b_rd_p2_q <= '0;
        end else begin
          a_rd_p2_q <= a_rd_p2_d;
          b_rd_p2_q <= b_rd_p2_d;
        end
      end

      assign a_di = a_rd_p2_q;
      assign b_di = b_rd_p2_q;
    end else begin : g_no_out_reg
      assign a_di = a_rd_p1_q;
      assign b_di = b_rd_p1_q;
    end
  endgenerate
endmodule

// File: tb/tb_dbram_be.sv
// Bench for dbram_be: directed vector table plus randomized traffic against a word-level model.
// Hand sequences cover the clear engine and the 64-bit output-register variant.
module tb_dbram_be;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // shared 32-bit stimulus for the read-first and write-first instances
  logic        rst   = 1'b1;
  logic [31:0] a_do  = '0, b_do = '0;
  logic [3:0]  a_sel = '0, b_sel = '0;
  logic        a_we  = 1'b0, b_we = 1'b0;
  logic [15:0] a_a   = '0, b_a = '0;
  logic [31:0] rf_a_di, rf_b_di, wf_a_di, wf_b_di;
  logic        rf_busy, wf_busy;

  // clear-engine instance, 16 words
  logic        c_rst   = 1'b1;
  logic [31:0] c_a_do  = '0, c_b_do = '0;
  logic [3:0]  c_a_sel = '0, c_b_sel = '0;
  logic        c_a_we  = 1'b0, c_b_we = 1'b0;
  logic [15:0] c_a_a   = '0, c_b_a = '0;
  logic [31:0] c_a_di, c_b_di;
  logic        c_busy;

  // 64-bit instance with output register
  logic [63:0] d_a_do  = '0, d_b_do = '0;
  logic [7:0]  d_a_sel = '0, d_b_sel = '0;
  logic        d_a_we  = 1'b0, d_b_we = 1'b0;
  logic [15:0] d_a_a   = '0, d_b_a = '0;
  logic [63:0] d_a_di, d_b_di;
  logic        d_busy;

  dbram_be #(.rdw_mode(0)) u_rf (
    .clk(clk), .rst(rst), .a_do(a_do), .a_sel(a_sel), .a_we(a_we), .a_a(a_a), .a_di(rf_a_di),
    .b_do(b_do), .b_sel(b_sel), .b_we(b_we), .b_a(b_a), .b_di(rf_b_di), .busy(rf_busy));

  dbram_be #(.rdw_mode(1)) u_wf (
    .clk(clk), .rst(rst), .a_do(a_do), .a_sel(a_sel), .a_we(a_we), .a_a(a_a), .a_di(wf_a_di),
    .b_do(b_do), .b_sel(b_sel), .b_we(b_we), .b_a(b_a), .b_di(wf_b_di), .busy(wf_busy));

  dbram_be #(.adr_width(6), .clear_on_reset(1)) u_clr (
    .clk(clk), .rst(c_rst), .a_do(c_a_do), .a_sel(c_a_sel), .a_we(c_a_we), .a_a(c_a_a),
    .a_di(c_a_di), .b_do(c_b_do), .b_sel(c_b_sel), .b_we(c_b_we), .b_a(c_b_a), .b_di(c_b_di),
    .busy(c_busy));

  dbram_be #(.data_width(64), .out_reg(1)) u_w64 (
    .clk(clk), .rst(rst), .a_do(d_a_do), .a_sel(d_a_sel), .a_we(d_a_we), .a_a(d_a_a),
    .a_di(d_a_di), .b_do(d_b_do), .b_sel(d_b_sel), .b_we(d_b_we), .b_a(d_b_a), .b_di(d_b_di),
    .busy(d_busy));

  typedef struct packed {
    logic        aw;
    logic [3:0]  as;
    logic [15:0] aa;
    logic [31:0] ad;
    logic        bw;
    logic [3:0]  bs;
    logic [15:0] ba;
    logic [31:0] bd;
    logic        chk;
    logic [31:0] ea0, eb0, ea1, eb1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic aw, input logic [3:0] as, input logic [15:0] aa,
                              input logic [31:0] ad, input logic bw, input logic [3:0] bs,
                              input logic [15:0] ba, input logic [31:0] bd, input logic chk,
                              input logic [31:0] ea0, input logic [31:0] eb0,
                              input logic [31:0] ea1, input logic [31:0] eb1);
    vec_t v;
    v.aw = aw; v.as = as; v.aa = aa; v.ad = ad;
    v.bw = bw; v.bs = bs; v.ba = ba; v.bd = bd;
    v.chk = chk; v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] m [4];
    int n;

    // aw as    aa        ad            bw bs    ba        bd            chk ea0/eb0 rdw0, ea1/eb1 rdw1
    tbl.push_back(mk(1, 4'hF, 16'h0010, 32'h0,        1, 4'hF, 16'h0020, 32'h11223344, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'h0000, 32'h0,        1, 4'hF, 16'h0030, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'h0010, 32'hDEADBEEF, 0, 4'hF, 16'h0010, 32'hFFFFFFFF, 1,
                     32'h0, 32'h0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 4'h0, 16'h0020, 32'h0,        0, 4'h0, 16'h0010, 32'h0,        1,
                     32'h11223344, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF));
    tbl.push_back(mk(1, 4'h5, 16'h0020, 32'hAABBCCDD, 0, 4'h0, 16'h0020, 32'h0,        1,
                     32'h11223344, 32'h11223344, 32'h11BB33DD, 32'h11223344));
    tbl.push_back(mk(0, 4'h0, 16'h0023, 32'h0,        0, 4'h0, 16'hF810, 32'h0,        1,
                     32'h11BB33DD, 32'hDEADBEEF, 32'h11BB33DD, 32'hDEADBEEF));
    tbl.push_back(mk(1, 4'hF, 16'h0010, 32'h0,        0, 4'h0, 16'h0020, 32'h0,        1,
                     32'hDEADBEEF, 32'h11BB33DD, 32'h0, 32'h11BB33DD));
    tbl.push_back(mk(1, 4'h3, 16'h0010, 32'hAAAAAAAA, 1, 4'h6, 16'h0010, 32'hBBBBBBBB, 1,
                     32'h0, 32'h0, 32'h0000AAAA, 32'h00BBBB00));
    tbl.push_back(mk(0, 4'h0, 16'h0010, 32'h0,        0, 4'h0, 16'h0012, 32'h0,        1,
                     32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA));
    tbl.push_back(mk(1, 4'hF, 16'h0000, 32'h5,        0, 4'h0, 16'h0000, 32'h0,        1,
                     32'h0, 32'h0, 32'h5, 32'h0));
    tbl.push_back(mk(0, 4'h0, 16'h0000, 32'h0,        0, 4'h0, 16'h0030, 32'h0,        1,
                     32'h5, 32'h0, 32'h5, 32'h0));
    tbl.push_back(mk(0, 4'h0, 16'h0020, 32'h0,        1, 4'h8, 16'h0030, 32'h77000000, 1,
                     32'h11BB33DD, 32'h0, 32'h11BB33DD, 32'h77000000));
    tbl.push_back(mk(0, 4'hF, 16'h0030, 32'hFFFFFFFF, 0, 4'h0, 16'h0010, 32'h0,        1,
                     32'h77000000, 32'h00BBAAAA, 32'h77000000, 32'h00BBAAAA));
    tbl.push_back(mk(0, 4'h0, 16'h0030, 32'h0,        0, 4'h0, 16'h0030, 32'h0,        1,
                     32'h77000000, 32'h77000000, 32'h77000000, 32'h77000000));

    // reset state of every instance
    tick();
    tick();
    check("rst rf_a_di", 64'(rf_a_di), 64'h0);
    check("rst rf_b_di", 64'(rf_b_di), 64'h0);
    check("rst wf_a_di", 64'(wf_a_di), 64'h0);
    check("rst wf_b_di", 64'(wf_b_di), 64'h0);
    check("rst rf_busy", 64'(rf_busy), 64'h0);
    check("rst wf_busy", 64'(wf_busy), 64'h0);
    check("rst w64 a_di", d_a_di, 64'h0);
    check("rst w64 b_di", d_b_di, 64'h0);
    check("rst w64 busy", 64'(d_busy), 64'h0);
    check("rst clr busy", 64'(c_busy), 64'h1);
    check("rst clr a_di", 64'(c_a_di), 64'h0);
    check("rst clr b_di", 64'(c_b_di), 64'h0);
    rst = 1'b0;

    // directed table
    foreach (tbl[i]) begin
      a_we = tbl[i].aw; a_sel = tbl[i].as; a_a = tbl[i].aa; a_do = tbl[i].ad;
      b_we = tbl[i].bw; b_sel = tbl[i].bs; b_a = tbl[i].ba; b_do = tbl[i].bd;
      tick();
      if (tbl[i].chk) begin
        check($sformatf("vec%0d rf_a", i), 64'(rf_a_di), 64'(tbl[i].ea0));
        check($sformatf("vec%0d rf_b", i), 64'(rf_b_di), 64'(tbl[i].eb0));
        check($sformatf("vec%0d wf_a", i), 64'(wf_a_di), 64'(tbl[i].ea1));
        check($sformatf("vec%0d wf_b", i), 64'(wf_b_di), 64'(tbl[i].eb1));
      end
    end

    // randomized traffic on words 16..19 against a word-level model
    a_we = 1'b1; b_we = 1'b1; a_sel = 4'hF; b_sel = 4'hF;
    for (int k = 0; k < 4; k += 2) begin
      a_a = 16'((16 + k) << 2);
      b_a = 16'((17 + k) << 2);
      a_do = $urandom;
      b_do = $urandom;
      m[k] = a_do;
      m[k+1] = b_do;
      tick();
    end
    for (int r = 0; r < 300; r++) begin
      int ai, bi;
      logic [31:0] ea0, eb0, ea1, eb1;
      ai = $urandom_range(3);
      bi = ($urandom_range(3) == 0) ? ai : $urandom_range(3);
      a_we = 1'($urandom_range(1)); b_we = 1'($urandom_range(1));
      a_sel = 4'($urandom); b_sel = 4'($urandom);
      a_do = $urandom; b_do = $urandom;
      a_a = {5'($urandom), 9'(16 + ai), 2'($urandom)};
      b_a = {5'($urandom), 9'(16 + bi), 2'($urandom)};
      ea0 = m[ai];
      eb0 = m[bi];
      ea1 = a_we ? merge(m[ai], a_do, a_sel) : m[ai];
      eb1 = b_we ? merge(m[bi], b_do, b_sel) : m[bi];
      if (b_we) m[bi] = merge(m[bi], b_do, b_sel);
      if (a_we) m[ai] = merge(m[ai], a_do, a_sel);
      tick();
      check($sformatf("rand%0d rf_a", r), 64'(rf_a_di), 64'(ea0));
      check($sformatf("rand%0d rf_b", r), 64'(rf_b_di), 64'(eb0));
      check($sformatf("rand%0d wf_a", r), 64'(wf_a_di), 64'(ea1));
      check($sformatf("rand%0d wf_b", r), 64'(wf_b_di), 64'(eb1));
    end
    a_we = 1'b0; b_we = 1'b0;

    // 64-bit output register: two-cycle latency and reset of the pipeline
    d_a_we = 1'b1; d_b_we = 1'b1; d_a_sel = '1; d_b_sel = '1;
    d_a_a = 16'h0100; d_b_a = 16'h0200; d_a_do = '0; d_b_do = '0;
    tick();
    d_a_do = 64'h0123456789ABCDEF; d_b_do = 64'hFEDCBA9876543210;
    tick();
    d_a_we = 1'b0; d_b_we = 1'b0; d_b_a = 16'h0104;
    tick();
    check("w64 a one cycle", d_a_di, 64'h0);
    check("w64 b one cycle", d_b_di, 64'h0);
    tick();
    check("w64 a two cycles", d_a_di, 64'h0123456789ABCDEF);
    check("w64 b two cycles", d_b_di, 64'h0123456789ABCDEF);
    rst = 1'b1;
    tick();
    check("w64 a after rst", d_a_di, 64'h0);
    check("w64 b after rst", d_b_di, 64'h0);
    rst = 1'b0;
    tick();
    check("w64 a pipe drained", d_a_di, 64'h0);
    tick();
    check("w64 a data kept", d_a_di, 64'h0123456789ABCDEF);
    check("w64 b data kept", d_b_di, 64'h0123456789ABCDEF);
    d_b_a = 16'h0207;
    tick();
    tick();
    check("w64 b second word", d_b_di, 64'hFEDCBA9876543210);

    // clear engine: busy length, dropped write, zeroed array, mid-clear restart
    c_a_we = 1'b1; c_a_sel = 4'hF; c_a_a = 16'h0014; c_a_do = 32'hCAFEF00D;
    c_b_a = 16'h0014;
    c_rst = 1'b0;
    n = 0;
    while (c_busy === 1'b1 && n < 40) begin
      check($sformatf("clr%0d a_di while busy", n), 64'(c_a_di), 64'h0);
      tick();
      n++;
    end
    c_a_we = 1'b0;
    check("clr busy cycles", 64'(n), 64'd16);
    for (int i = 0; i < 16; i++) begin
      c_a_a = 16'((i << 2) | $urandom_range(3));
      c_b_a = 16'((15 - i) << 2);
      tick();
      check($sformatf("clr word%0d a", i), 64'(c_a_di), 64'h0);
      check($sformatf("clr word%0d b", 15 - i), 64'(c_b_di), 64'h0);
    end
    c_a_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c_a_a = 16'(i << 2);
      c_a_do = 32'h1000 + 32'(i);
      tick();
    end
    c_a_we = 1'b0;
    c_a_a = 16'h000C;
    tick();
    check("clr refill word3", 64'(c_a_di), 64'h1003);
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    repeat (8) tick();
    check("clr busy mid", 64'(c_busy), 64'h1);
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    n = 0;
    while (c_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("clr restart busy cycles", 64'(n), 64'd16);
    for (int i = 0; i < 16; i++) begin
      c_a_a = 16'(i << 2);
      c_b_a = 16'(((15 - i) << 2) | 2);
      tick();
      check($sformatf("clr2 word%0d a", i), 64'(c_a_di), 64'h0);
      check($sformatf("clr2 word%0d b", 15 - i), 64'(c_b_di), 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
